rom_dl_router: RTL and testbench

Parametrised ROM-download router for arcade cores. It takes the HPS `ioctl` byte stream and steers each byte to one of `NREG` memory regions by address, using a toggle req/ack handshake, and back-pressures the HPS with `ioctl_wait`. It also captures the core-mod byte and generates the post-load core reset. It sits between `hps_io` and the SDRAM ports / BRAM ROMs in `emu`, and replaces the per-core hand-written download controller and reset counter.

---
 rtl/rom_dl_router.sv | 164 ++++++++++++++++
 tb/tb_rom_dl_router.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_router.sv
// ROM-download router: steers the HPS ioctl byte stream to NREG regions over a
// toggle req/ack handshake and generates the post-load core reset. Optional ack timeout: ROMDL_TIMEOUT_EN.
module rom_dl_router #(
  parameter int              NREG         = 4,
  parameter logic [NREG*32-1:0] REG_BASE  = {32'hA0000, 32'h30000, 32'h20000, 32'h0},
  parameter logic [7:0]      ROM_INDEX    = 8'd0,
  parameter logic [7:0]      MOD_INDEX    = 8'd1,
  parameter logic [15:0]     RESET_CYCLES = 16'hFFFF,
  parameter int              TIMEOUT      = 1023
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            user_reset,
  input  logic            ioctl_download,
  input  logic [7:0]      ioctl_index,
  input  logic            ioctl_wr,
  input  logic [24:0]     ioctl_addr,
  input  logic [7:0]      ioctl_dout,
  output logic            ioctl_wait,
  output logic [NREG-1:0] rgn_req,
  input  logic [NREG-1:0] rgn_ack,
  output logic [NREG-1:0] rgn_we,
  output logic [24:0]     rgn_addr,
  output logic [7:0]      rgn_data,
  output logic [7:0]      core_mod,
  output logic            rom_loaded,
  output logic            core_reset,
  output logic [15:0]     drop_cnt,
  output logic            err
);

`ifdef ROMDL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state;
  logic [SW-1:0]   sel;
  logic [TW-1:0]   tcnt;
  logic            err_q;
  logic            wr_last;
  logic            dl_last;
  logic [15:0]     cnt;

  logic            hit_c;
  logic [SW-1:0]   sel_c;
  logic [24:0]     base_c;
  logic [24:0]     off_c;
  logic            accept;
  logic            ack_match;
  logic            dl_rom;
  logic            load_cond;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Bases ascend, so the last matching region in the scan is the highest one.
  always_comb begin
    hit_c  = 1'b0;
    sel_c  = '0;
    base_c = '0;
    for (int i = 0; i < NREG; i++) begin
      if ({7'd0, ioctl_addr} >= REG_BASE[32*i +: 32]) begin
        hit_c  = 1'b1;
        sel_c  = SW'(i);
        base_c = REG_BASE[32*i +: 25];
      end
    end
  end

  assign off_c     = ioctl_addr - base_c;
  assign accept    = ioctl_wr & ~wr_last & ioctl_download & (ioctl_index == ROM_INDEX);
  assign ack_match = (rgn_ack[sel] == rgn_req[sel]);
  assign dl_rom    = ioctl_download & (ioctl_index == ROM_INDEX);
  assign load_cond = user_reset | ~rom_loaded | dl_rom;
  assign err       = TO_EN & err_q;

  // Download FSM and handshake
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      sel        <= '0;
      tcnt       <= '0;
      err_q      <= 1'b0;
      ioctl_wait <= 1'b0;
      rgn_req    <= '0;
      rgn_we     <= '0;
      rgn_addr   <= '0;
      rgn_data   <= '0;
      drop_cnt   <= '0;
      wr_last    <= 1'b0;
    end else begin
      wr_last <= ioctl_wr;
      rgn_we  <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (hit_c) begin
              sel            <= sel_c;
              rgn_addr       <= off_c;
              rgn_data       <= ioctl_dout;
              rgn_req[sel_c] <= ~rgn_req[sel_c];
              rgn_we[sel_c]  <= 1'b1;
              ioctl_wait     <= 1'b1;
              tcnt           <= '0;
              state          <= S_WAIT;
            end else begin
              drop_cnt <= sat_inc(drop_cnt);
            end
          end
        end
        S_WAIT: begin
          if (accept) drop_cnt <= sat_inc(drop_cnt);
          if (ack_match) begin
            ioctl_wait <= 1'b0;
            state      <= S_IDLE;
          end else if (TO_EN && (tcnt == TW'(TIMEOUT - 1))) begin
            // Give up on the peer and adopt its current ack as the new baseline.
            err_q        <= 1'b1;
            ioctl_wait   <= 1'b0;
            rgn_req[sel] <= rgn_ack[sel];
            state        <= S_IDLE;
          end else if (TO_EN) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Load tracking, core-mod capture and core reset counter
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_last    <= 1'b0;
      rom_loaded <= 1'b0;
      core_mod   <= 8'd0;
      cnt        <= RESET_CYCLES;
      core_reset <= 1'b1;
    end else begin
      dl_last <= dl_rom;
      if (dl_rom && !dl_last)
        rom_loaded <= 1'b0;
      else if (!dl_rom && dl_last)
        rom_loaded <= 1'b1;
      if (ioctl_wr && (ioctl_index == MOD_INDEX))
        core_mod <= ioctl_dout;
      if (load_cond)
        cnt <= RESET_CYCLES;
      else if (cnt != 16'd0)
        cnt <= cnt - 16'd1;
      // Including load_cond asserts core reset on the cycle right after a reload starts.
      core_reset <= load_cond | (cnt != 16'd0);
    end
  end

endmodule

// File: tb/tb_rom_dl_router.sv
// Self-checking bench for rom_dl_router: table vectors, randomized writes against a
// region-select model, and hand-written handshake/reset/counter sequences.
module tb_rom_dl_router;
  localparam logic [31:0] B0 = 32'h00100;
  localparam logic [31:0] B1 = 32'h20000;
  localparam logic [31:0] B2 = 32'h30000;
  localparam logic [31:0] B3 = 32'hA0000;
  localparam logic [127:0] TB_BASE = {B3, B2, B1, B0};
  localparam int RC = 20;
  localparam int TO = 8;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        user_reset = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic [3:0]  rgn_req, rgn_ack, rgn_we;
  logic [24:0] rgn_addr;
  logic [7:0]  rgn_data, core_mod;
  logic        rom_loaded, core_reset, err;
  logic [15:0] drop_cnt;

  // Region 0 peer: loopback, or an ack that returns dly cycles after the request toggles.
  logic lb0 = 1'b1, hold = 1'b0, ack0;
  int   dly = 1, pc;

  always #5 clk_sys = ~clk_sys;

  rom_dl_router #(
    .NREG(4), .REG_BASE(TB_BASE), .ROM_INDEX(8'd0), .MOD_INDEX(8'd1),
    .RESET_CYCLES(RC[15:0]), .TIMEOUT(TO)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .user_reset(user_reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .rgn_req(rgn_req), .rgn_ack(rgn_ack), .rgn_we(rgn_we), .rgn_addr(rgn_addr),
    .rgn_data(rgn_data), .core_mod(core_mod), .rom_loaded(rom_loaded),
    .core_reset(core_reset), .drop_cnt(drop_cnt), .err(err)
  );

  assign rgn_ack = {rgn_req[3:1], lb0 ? rgn_req[0] : ack0};

  always @(posedge clk_sys) begin
    if (reset) begin
      ack0 <= 1'b0;
      pc   <= 0;
    end else if (lb0) begin
      ack0 <= rgn_req[0];
      pc   <= 0;
    end else if (!hold && (ack0 != rgn_req[0])) begin
      if (pc == dly - 1) begin
        ack0 <= rgn_req[0];
        pc   <= 0;
      end else begin
        pc <= pc + 1;
      end
    end
  end

  typedef struct { logic [3:0] we; logic [24:0] addr; logic [7:0] data; } txn_t;
  txn_t       mon_q[$];
  txn_t       mt;
  int         tog[4] = '{0, 0, 0, 0};
  logic [3:0] req_prev = 4'b0;

  always begin
    @(posedge clk_sys);
    #2;
    if (rgn_we != 4'b0) begin
      mt.we = rgn_we; mt.addr = rgn_addr; mt.data = rgn_data;
      mon_q.push_back(mt);
    end
    for (int i = 0; i < 4; i++) if (rgn_req[i] != req_prev[i]) tog[i]++;
    req_prev = rgn_req;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Highest region whose base is at or below the address; -1 when none.
  function automatic int model_rgn(input logic [24:0] a, output logic [24:0] off);
    logic [31:0] b[4];
    int r;
    b[0] = B0; b[1] = B1; b[2] = B2; b[3] = B3;
    r = -1; off = '0;
    for (int i = 0; i < 4; i++)
      if ({7'd0, a} >= b[i]) begin r = i; off = a - b[i][24:0]; end
    return r;
  endfunction

  task automatic send(input logic [24:0] a, input logic [7:0] d, output int wcyc);
    @(negedge clk_sys);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    wcyc = 0;
    while (ioctl_wait && wcyc < 100) begin
      wcyc++;
      @(negedge clk_sys);
    end
    @(negedge clk_sys);
  endtask

  task automatic check_txn(input string nm, input int r, input logic [24:0] off,
                           input logic [7:0] d, input int wcyc, input logic [15:0] drop0);
    if (r < 0) begin
      chk({nm, "_drop_wait"}, wcyc, 0);
      chk({nm, "_drop_nowe"}, mon_q.size(), 0);
      chk({nm, "_drop_cnt"}, drop_cnt - drop0, 1);
    end else begin
      chk({nm, "_wait"}, wcyc, 1);
      chk({nm, "_nwe"}, mon_q.size(), 1);
      if (mon_q.size() > 0) begin
        chk({nm, "_we"}, mon_q[0].we, 4'b1 << r);
        chk({nm, "_addr"}, mon_q[0].addr, off);
        chk({nm, "_data"}, mon_q[0].data, d);
      end
    end
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_wait"}, ioctl_wait, 0);
    chk({nm, "_req"}, rgn_req, 0);
    chk({nm, "_we"}, rgn_we, 0);
    chk({nm, "_addr"}, rgn_addr, 0);
    chk({nm, "_data"}, rgn_data, 0);
    chk({nm, "_mod"}, core_mod, 0);
    chk({nm, "_loaded"}, rom_loaded, 0);
    chk({nm, "_drop"}, drop_cnt, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_creset"}, core_reset, 1);
  endtask

  typedef struct { logic [24:0] addr; logic [7:0] data; int rgn; logic [24:0] off; } vec_t;
  vec_t tbl[7];

  initial begin
    int wcyc, t0[4], n, r;
    logic [15:0] drop0;
    logic [24:0] a, off;
    logic [7:0]  d;

    tbl[0] = '{25'h0020010, 8'h55, 1, 25'h0000010};
    tbl[1] = '{25'h00A0000, 8'h3C, 3, 25'h0000000};
    tbl[2] = '{25'h009FFFF, 8'hC3, 2, 25'h006FFFF};
    tbl[3] = '{25'h0000100, 8'h01, 0, 25'h0000000};
    tbl[4] = '{25'h001FFFF, 8'h7E, 0, 25'h001FEFF};
    tbl[5] = '{25'h00000FF, 8'h99, -1, 25'h0000000};
    tbl[6] = '{25'h1FFFFFF, 8'hAA, 3, 25'h1F5FFFF};

    repeat (3) @(negedge clk_sys);
    check_reset_vals("rst");
    reset = 1'b0;
    ioctl_download = 1'b1; ioctl_index = 8'd0;
    repeat (2) @(negedge clk_sys);

    for (int k = 0; k < 7; k++) begin
      mon_q.delete(); t0 = tog; drop0 = drop_cnt;
      send(tbl[k].addr, tbl[k].data, wcyc);
      check_txn($sformatf("tbl%0d", k), tbl[k].rgn, tbl[k].off, tbl[k].data, wcyc, drop0);
      for (int i = 0; i < 4; i++)
        chk($sformatf("tbl%0d_tog%0d", k, i), tog[i] - t0[i], (tbl[k].rgn == i) ? 1 : 0);
    end

    for (int k = 0; k < 150; k++) begin
      n = $urandom_range(0, 15);
      if (n < 2)       a = 25'($urandom_range(0, 32'hFF));
      else if (n == 2) a = 25'($urandom);
      else             a = 25'($urandom_range(0, 32'hBFFFF));
      d = 8'($urandom);
      r = model_rgn(a, off);
      mon_q.delete(); drop0 = drop_cnt;
      send(a, d, wcyc);
      check_txn("rand", r, off, d, wcyc, drop0);
      repeat ($urandom_range(0, 2)) @(negedge clk_sys);
    end

    // Region 0 ack returns 19 cycles after its request, so wait holds for 20 cycles;
    // a second edge during the wait is discarded.
    lb0 = 1'b0; dly = 19;
    mon_q.delete(); t0 = tog; drop0 = drop_cnt;
    @(negedge clk_sys);
    ioctl_addr = 25'h200; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    wcyc = 0;
    while (ioctl_wait && wcyc < 100) begin
      wcyc++;
      if (wcyc == 4) begin
        ioctl_addr = 25'h300; ioctl_dout = 8'h22; ioctl_wr = 1'b1;
      end else if (wcyc == 5) begin
        ioctl_wr = 1'b0;
      end
      @(negedge clk_sys);
    end
    @(negedge clk_sys);
    chk("dly_wait", wcyc, 20);
    chk("dly_drop", drop_cnt - drop0, 1);
    chk("dly_tog0", tog[0] - t0[0], 1);
    chk("dly_nwe", mon_q.size(), 1);
    if (mon_q.size() > 0) begin
      chk("dly_addr", mon_q[0].addr, 25'h100);
      chk("dly_data", mon_q[0].data, 8'h11);
    end
    lb0 = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Download end: rom_loaded next cycle, core reset drops RC+2 cycles later.
    chk("load_before", rom_loaded, 0);
    ioctl_download = 1'b0;
    n = 0;
    while (core_reset && n < RC + 10) begin
      @(negedge clk_sys);
      n++;
      if (n == 1) chk("load_rise", rom_loaded, 1);
    end
    chk("creset_fall", n, RC + 2);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    chk("reload_loaded", rom_loaded, 0);
    chk("reload_creset", core_reset, 1);

    ioctl_download = 1'b0;
    repeat (RC + 4) @(negedge clk_sys);
    chk("ureset_pre", core_reset, 0);
    user_reset = 1'b1;
    @(negedge clk_sys);
    user_reset = 1'b0;
    chk("ureset_creset", core_reset, 1);

    ioctl_index = 8'd1;
    mon_q.delete(); t0 = tog;
    send(25'h20000, 8'h0B, wcyc);
    chk("mod_val", core_mod, 8'h0B);
    chk("mod_nwe", mon_q.size(), 0);
    chk("mod_notog", (tog[0] - t0[0]) + (tog[1] - t0[1]) + (tog[2] - t0[2]) + (tog[3] - t0[3]), 0);

    // Reset while waiting on an ack that never comes.
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    lb0 = 1'b0; hold = 1'b1;
    @(negedge clk_sys);
    ioctl_addr = 25'h400; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("midrst_waiting", ioctl_wait, 1);
    ioctl_download = 1'b0;
    reset = 1'b1;
    @(negedge clk_sys);
    check_reset_vals("midrst");
    reset = 1'b0; hold = 1'b0; lb0 = 1'b1;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);

`ifdef ROMDL_TIMEOUT_EN
    lb0 = 1'b0; hold = 1'b1;
    send(25'h400, 8'h66, wcyc);
    chk("to_wait", wcyc, TO);
    chk("to_err", err, 1);
    hold = 1'b0; lb0 = 1'b1;
    mon_q.delete();
    send(25'h500, 8'h77, wcyc);
    check_txn("to_next", 0, 25'h400, 8'h77, wcyc, drop_cnt);
    chk("to_err_sticky", err, 1);
`else
    chk("err_tied", err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
